// File: rtl/main_mem_ctrl.sv
// Main-memory controller: serves 4-beat block refills and write-backs for the cache over a
// shared tri-state byte bus. Optional MEM_INIT_EN preloads storage with mem[a] = a[7:0] ^ 8'hA5.
module main_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_AW     = 10,
    parameter int unsigned RD_LATENCY = 4,
    parameter int unsigned WR_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] addr_mem,
    input  logic                  rd_mem,
    input  logic                  wr_mem,
    inout  wire  [DATA_WIDTH-1:0] data_mem,
    output logic                  ready_mem,
    output logic                  mem_vld
);

    localparam int unsigned BlkW   = MEM_AW - 2;
    localparam int unsigned MaxLat = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

    typedef enum logic [2:0] {StIdle, StRdWait, StRdBurst, StWrBurst, StWrWait} state_e;

    state_e                state_q, state_d;
    logic [BlkW-1:0]       blk_q, blk_d;
    logic [1:0]            beat_q, beat_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mem_we;
    logic                  bus_drive;

    logic [DATA_WIDTH-1:0] mem [0:(1 << MEM_AW)-1];

`ifdef MEM_INIT_EN
    initial begin
        for (int a = 0; a < (1 << MEM_AW); a++) begin
            mem[a] = DATA_WIDTH'(a[7:0] ^ 8'hA5);
        end
    end
`else
    // Storage powers up unknown; never-written bytes read back as X.
`endif

    // Block offset and aliased upper bits are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{addr_mem[ADDR_WIDTH-1:MEM_AW], addr_mem[1:0]};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            blk_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage has no reset; a reset edge must not commit a pending write beat.
    always_ff @(posedge clock) begin
        if (reset_n && mem_we) begin
            mem[{blk_q, beat_q}] <= data_mem;
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                beat_d = '0;
                cnt_d  = '0;
                if (wr_mem) begin
                    blk_d   = addr_mem[MEM_AW-1:2];
                    state_d = StWrBurst;
                end else if (rd_mem) begin
                    blk_d   = addr_mem[MEM_AW-1:2];
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (cnt_q == CntW'(RD_LATENCY - 1)) begin
                    cnt_d   = '0;
                    beat_d  = '0;
                    rdata_d = mem[{blk_q, 2'b00}];
                    state_d = StRdBurst;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRdBurst: begin
                if (beat_q == 2'd3) begin
                    beat_d  = '0;
                    state_d = StIdle;
                end else begin
                    beat_d  = beat_q + 2'd1;
                    rdata_d = mem[{blk_q, beat_q + 2'd1}];
                end
            end
            StWrBurst: begin
                mem_we = 1'b1;
                if (beat_q == 2'd3) begin
                    beat_d  = '0;
                    state_d = StWrWait;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            StWrWait: begin
                if (cnt_q == CntW'(WR_LATENCY - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_mem = (state_q == StIdle);
        mem_vld   = (state_q == StRdBurst);
        bus_drive = (state_q == StRdBurst);
    end

    assign data_mem = bus_drive ? rdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl: read timing, write-back, priority, busy-ignore, reset, aliasing.
module tb_main_mem_ctrl;

    localparam logic [7:0] Probe = 8'h5A;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd_mem = 1'b0;
    logic        wr_mem = 1'b0;
    logic [15:0] addr_mem = 16'h0000;
    wire  [7:0]  data_mem;
    logic [7:0]  tb_drv = 8'h00;
    logic        tb_oe = 1'b0;
    logic        ready_mem;
    logic        mem_vld;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench drives the bus during write beats and with a probe pattern where the DUT must be off.
    assign data_mem = tb_oe ? tb_drv : 8'hzz;

    always #5 clock = ~clock;

    main_mem_ctrl dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .addr_mem (addr_mem),
        .rd_mem   (rd_mem),
        .wr_mem   (wr_mem),
        .data_mem (data_mem),
        .ready_mem(ready_mem),
        .mem_vld  (mem_vld)
    );

    task automatic do_write(input logic [15:0] a, input logic [3:0][7:0] bytes, input bit also_rd,
                            output int busy, output int bad, output int nvld, output bit tmo);
        bit done;
        busy = 0; bad = 0; nvld = 0; done = 1'b0;
        @(negedge clock);
        addr_mem = a; wr_mem = 1'b1; rd_mem = also_rd;
        @(negedge clock);
        wr_mem = 1'b0; rd_mem = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (k > 0) @(negedge clock);
            if (ready_mem) begin
                done = 1'b1;
                break;
            end
            busy++;
            tb_oe  = 1'b1;
            tb_drv = (k < 4) ? bytes[k] : Probe;
            #1;
            if (data_mem !== tb_drv) bad++;
            if (mem_vld !== 1'b0) nvld++;
        end
        tb_oe = 1'b0;
        tmo = !done;
    endtask

    task automatic do_read(input logic [15:0] a, input bit poke, input logic [15:0] pa,
                           output logic [3:0][7:0] d, output int busy, output int nvld,
                           output int first, output logic vld_after, output logic [7:0] rel,
                           output bit tmo);
        bit done;
        d = '0; busy = 0; nvld = 0; first = -1; done = 1'b0;
        @(negedge clock);
        addr_mem = a; rd_mem = 1'b1;
        @(negedge clock);
        rd_mem = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (k > 0) @(negedge clock);
            if (poke) begin
                rd_mem = (k == 1 || k == 2);
                if (k == 1) addr_mem = pa;
            end
            if (ready_mem) begin
                done = 1'b1;
                break;
            end
            busy++;
            if (mem_vld === 1'b1) begin
                if (nvld < 4) d[nvld] = data_mem;
                if (nvld == 0) first = busy;
                nvld++;
            end
        end
        rd_mem    = 1'b0;
        vld_after = mem_vld;
        tb_oe     = 1'b1;
        tb_drv    = Probe;
        #1;
        rel   = data_mem;
        tb_oe = 1'b0;
        tmo   = !done;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (ready_mem !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_mem);
        end
        n_checks++;
        if (mem_vld !== 1'b0) begin
            n_fail++; $display("FAIL reset_vld: got %b expected 0", mem_vld);
        end
        tb_oe = 1'b1; tb_drv = Probe; #1;
        n_checks++;
        if (data_mem !== Probe) begin
            n_fail++; $display("FAIL reset_release: got %h expected %h", data_mem, Probe);
        end
        tb_oe = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_read_latency();
        logic [3:0][7:0] d;
        logic [3:0][7:0] exp_d;
        int busy, nvld, first, bad;
        logic vld_after;
        logic [7:0] rel;
        bit tmo;
        exp_d = 32'h2E2F2C2D;
`ifndef MEM_INIT_EN
        // Without preload, place the preload pattern of this block by a write first.
        do_write(16'hC08B, exp_d, 1'b0, busy, bad, nvld, tmo);
`endif
        do_read(16'hC08B, 1'b0, 16'h0000, d, busy, nvld, first, vld_after, rel, tmo);
        n_checks++;
        if (tmo || busy != 8) begin
            n_fail++; $display("FAIL rd_busy: got %0d cycles expected 8", busy);
        end
        n_checks++;
        if (nvld != 4) begin
            n_fail++; $display("FAIL rd_vld_count: got %0d expected 4", nvld);
        end
        n_checks++;
        if (first != 5) begin
            n_fail++; $display("FAIL rd_first_beat: got busy cycle %0d expected 5", first);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (d[i] !== exp_d[i]) begin
                n_fail++; $display("FAIL rd_data[%0d]: got %h expected %h", i, d[i], exp_d[i]);
            end
        end
        n_checks++;
        if (vld_after !== 1'b0 || rel !== Probe) begin
            n_fail++; $display("FAIL rd_release: got vld %b bus %h expected vld 0 bus %h",
                               vld_after, rel, Probe);
        end
    endtask

    task automatic test_write_readback();
        logic [3:0][7:0] d;
        logic [3:0][7:0] wd;
        int busy, nvld, first, bad;
        logic vld_after;
        logic [7:0] rel;
        bit tmo;
        wd = 32'h44332211;
        do_write(16'h0093, wd, 1'b0, busy, bad, nvld, tmo);
        n_checks++;
        if (tmo || busy != 6) begin
            n_fail++; $display("FAIL wr_busy: got %0d cycles expected 6", busy);
        end
        n_checks++;
        if (bad != 0 || nvld != 0) begin
            n_fail++; $display("FAIL wr_bus_driven: got %0d/%0d expected 0/0", bad, nvld);
        end
        do_read(16'h0090, 1'b0, 16'h0000, d, busy, nvld, first, vld_after, rel, tmo);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (d[i] !== wd[i]) begin
                n_fail++; $display("FAIL wrrd_data[%0d]: got %h expected %h", i, d[i], wd[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0][7:0] d;
        logic [3:0][7:0] wd;
        int busy, nvld, first, bad, idle_bad;
        logic vld_after;
        logic [7:0] rel;
        bit tmo;
        wd = 32'h64636261;
        do_write(16'h0010, wd, 1'b1, busy, bad, nvld, tmo);
        n_checks++;
        if (tmo || busy != 6) begin
            n_fail++; $display("FAIL sim_busy: got %0d cycles expected 6", busy);
        end
        n_checks++;
        if (bad != 0 || nvld != 0) begin
            n_fail++; $display("FAIL sim_bus_driven: got %0d/%0d expected 0/0", bad, nvld);
        end
        idle_bad = 0;
        repeat (2) begin
            @(negedge clock);
            if (ready_mem !== 1'b1) idle_bad++;
        end
        n_checks++;
        if (idle_bad != 0) begin
            n_fail++; $display("FAIL sim_no_read: got %0d busy cycles expected 0", idle_bad);
        end
        do_read(16'h0010, 1'b0, 16'h0000, d, busy, nvld, first, vld_after, rel, tmo);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (d[i] !== wd[i]) begin
                n_fail++; $display("FAIL sim_data[%0d]: got %h expected %h", i, d[i], wd[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [3:0][7:0] d;
        logic [3:0][7:0] exp_d;
        int busy, nvld, first, idle_bad;
        logic vld_after;
        logic [7:0] rel;
        bit tmo;
        exp_d = 32'h44332211;
        do_read(16'h0090, 1'b1, 16'h0010, d, busy, nvld, first, vld_after, rel, tmo);
        n_checks++;
        if (tmo || busy != 8) begin
            n_fail++; $display("FAIL busy_ign_busy: got %0d cycles expected 8", busy);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (d[i] !== exp_d[i]) begin
                n_fail++; $display("FAIL busy_ign_data[%0d]: got %h expected %h", i, d[i], exp_d[i]);
            end
        end
        idle_bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (ready_mem !== 1'b1 || mem_vld !== 1'b0) idle_bad++;
        end
        n_checks++;
        if (idle_bad != 0) begin
            n_fail++; $display("FAIL busy_ign_second: got %0d busy cycles expected 0", idle_bad);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0][7:0] d;
        logic [3:0][7:0] exp_d;
        int busy, nvld, first, w;
        logic vld_after;
        logic [7:0] rel;
        bit tmo;
        exp_d = 32'h44332211;
        @(negedge clock);
        addr_mem = 16'h0090; rd_mem = 1'b1;
        @(negedge clock);
        rd_mem = 1'b0;
        w = 0;
        while (mem_vld !== 1'b1 && w < 20) begin
            @(negedge clock);
            w++;
        end
        n_checks++;
        if (mem_vld !== 1'b1) begin
            n_fail++; $display("FAIL rst_burst_start: got vld %b expected 1", mem_vld);
        end
        @(negedge clock);
        n_checks++;
        if (data_mem !== exp_d[1]) begin
            n_fail++; $display("FAIL rst_beat1: got %h expected %h", data_mem, exp_d[1]);
        end
        reset_n = 1'b0;
        @(negedge clock);
        n_checks++;
        if (ready_mem !== 1'b1 || mem_vld !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_state: got ready %b vld %b expected 1 0",
                               ready_mem, mem_vld);
        end
        tb_oe = 1'b1; tb_drv = Probe; #1;
        n_checks++;
        if (data_mem !== Probe) begin
            n_fail++; $display("FAIL rst_mid_release: got %h expected %h", data_mem, Probe);
        end
        tb_oe = 1'b0;
        reset_n = 1'b1;
        do_read(16'h0090, 1'b0, 16'h0000, d, busy, nvld, first, vld_after, rel, tmo);
        n_checks++;
        if (tmo || busy != 8) begin
            n_fail++; $display("FAIL rst_reread_busy: got %0d cycles expected 8", busy);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (d[i] !== exp_d[i]) begin
                n_fail++; $display("FAIL rst_reread[%0d]: got %h expected %h", i, d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_aliasing();
        logic [3:0][7:0] d;
        logic [3:0][7:0] wd;
        int busy, nvld, first, bad;
        logic vld_after;
        logic [7:0] rel;
        bit tmo;
        wd = 32'hDDCCBBAA;
        do_write(16'h0400, wd, 1'b0, busy, bad, nvld, tmo);
        do_read(16'h0000, 1'b0, 16'h0000, d, busy, nvld, first, vld_after, rel, tmo);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (d[i] !== wd[i]) begin
                n_fail++; $display("FAIL alias_data[%0d]: got %h expected %h", i, d[i], wd[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write_readback();
        test_simultaneous();
        test_busy_ignore();
        test_reset_mid_burst();
        test_aliasing();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
